// File: rtl/axil_ram_stream_reader.sv
// rtl/axil_ram_stream_reader.sv - AXI-Lite read master streaming a RAM region; optional AXIL_STREAM_RRESP_TUSER_EN
module axil_ram_stream_reader #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
`ifdef AXIL_STREAM_RRESP_TUSER_EN
    output logic [1:0]            m_axis_tuser,
`endif
    output logic                  busy,
    output logic                  rd_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int NW = LEN_WIDTH + 1;
`ifdef AXIL_STREAM_RRESP_TUSER_EN
    localparam int FW = DATA_WIDTH + 2;
`else
    localparam int FW = DATA_WIDTH;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t                state, state_n;
    logic [NW-1:0]         issue_rem, issue_n, beat_rem, beat_n;
    logic [CW-1:0]         outstanding, out_n, count, count_n;
    logic [CW:0]           credit_used;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [FW-1:0]         mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] araddr_n;
    logic                  arvalid_n;
    logic                  ar_fire, r_fire, t_fire;

    assign cmd_ready      = (state == S_IDLE);
    assign busy           = (state != S_IDLE);
    assign m_axil_arprot  = 3'b000;
    assign m_axil_rready  = busy && (count < CW'(FIFO_DEPTH));
    assign m_axis_tvalid  = (count != '0);
    assign m_axis_tdata   = mem[rd_ptr][DATA_WIDTH-1:0];
    assign m_axis_tlast   = m_axis_tvalid && (beat_rem == NW'(1));
`ifdef AXIL_STREAM_RRESP_TUSER_EN
    assign m_axis_tuser   = mem[rd_ptr][FW-1:DATA_WIDTH];
`endif

    assign ar_fire = m_axil_arvalid && m_axil_arready;
    assign r_fire  = m_axil_rvalid && m_axil_rready;
    assign t_fire  = m_axis_tvalid && m_axis_tready;

    always_comb begin
        state_n  = state;
        issue_n  = issue_rem;
        beat_n   = beat_rem;
        araddr_n = m_axil_araddr;
        out_n    = outstanding + CW'(ar_fire) - CW'(r_fire);
        count_n  = count + CW'(r_fire) - CW'(t_fire);
        if (t_fire) begin
            beat_n = beat_rem - NW'(1);
            if (state == S_DRAIN && beat_rem == NW'(1))
                state_n = S_IDLE;
        end
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_n  = S_ISSUE;
                    issue_n  = NW'(cmd_len) + NW'(1);
                    beat_n   = NW'(cmd_len) + NW'(1);
                    araddr_n = cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
                end
            end
            S_ISSUE: begin
                if (ar_fire) begin
                    issue_n  = issue_rem - NW'(1);
                    araddr_n = m_axil_araddr + ADDR_WIDTH'(STRB_WIDTH);
                    if (issue_rem == NW'(1))
                        state_n = S_DRAIN;
                end
            end
            default: ;
        endcase
        // Credit counts both in-flight reads and buffered words, so every R beat has a FIFO slot.
        credit_used = {1'b0, out_n} + {1'b0, count_n};
        if (m_axil_arvalid && !m_axil_arready)
            arvalid_n = 1'b1;
        else
            arvalid_n = (state_n == S_ISSUE) && (issue_n != '0) &&
                        (credit_used < (CW + 1)'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state          <= S_IDLE;
            issue_rem      <= '0;
            beat_rem       <= '0;
            outstanding    <= '0;
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            m_axil_araddr  <= '0;
            m_axil_arvalid <= 1'b0;
            rd_err         <= 1'b0;
        end else begin
            state          <= state_n;
            issue_rem      <= issue_n;
            beat_rem       <= beat_n;
            outstanding    <= out_n;
            count          <= count_n;
            m_axil_araddr  <= araddr_n;
            m_axil_arvalid <= arvalid_n;
            if (r_fire)
                wr_ptr <= wr_ptr + PW'(1);
            if (t_fire)
                rd_ptr <= rd_ptr + PW'(1);
            if (cmd_ready && cmd_valid)
                rd_err <= 1'b0;
            else if (r_fire && m_axil_rresp != 2'b00)
                rd_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_fire) begin
`ifdef AXIL_STREAM_RRESP_TUSER_EN
            mem[wr_ptr] <= {m_axil_rresp, m_axil_rdata};
`else
            mem[wr_ptr] <= m_axil_rdata;
`endif
        end
    end
endmodule

// File: tb/tb_axil_ram_stream_reader.sv
// tb/tb_axil_ram_stream_reader.sv - directed vector bench for axil_ram_stream_reader with a RAM slave model
module tb_axil_ram_stream_reader;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [8:0]  cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [8:0]  m_axil_araddr;
    logic [2:0]  m_axil_arprot;
    logic        m_axil_arvalid;
    logic        m_axil_arready;
    logic [15:0] m_axil_rdata;
    logic [1:0]  m_axil_rresp;
    logic        m_axil_rvalid;
    logic        m_axil_rready;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
`ifdef AXIL_STREAM_RRESP_TUSER_EN
    logic [1:0]  m_axis_tuser;
`endif
    logic        busy;
    logic        rd_err;

    axil_ram_stream_reader dut (
        .clk(clk), .rstn(rstn),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
`ifdef AXIL_STREAM_RRESP_TUSER_EN
        .m_axis_tuser(m_axis_tuser),
`endif
        .busy(busy), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // RAM slave: word at byte address a holds 0x1000 + a[8:1]; one cycle read latency.
    logic [8:0] pend[$];
    logic [8:0] head;
    logic       ar_throttle = 1'b0;
    int         err_word = -1;

    always @(posedge clk) begin
        if (!rstn) begin
            pend.delete();
            m_axil_rvalid  <= 1'b0;
            m_axil_rdata   <= '0;
            m_axil_rresp   <= 2'b00;
            m_axil_arready <= 1'b1;
        end else begin
            if (m_axil_rvalid && m_axil_rready) void'(pend.pop_front());
            if (m_axil_arvalid && m_axil_arready) pend.push_back(m_axil_araddr);
            m_axil_arready <= ar_throttle ? ~m_axil_arready : 1'b1;
            if (pend.size() != 0) begin
                head = pend[0];
                m_axil_rvalid <= 1'b1;
                m_axil_rdata  <= 16'h1000 + {8'h00, head[8:1]};
                m_axil_rresp  <= (int'(head[8:1]) == err_word) ? 2'b10 : 2'b00;
            end else begin
                m_axil_rvalid <= 1'b0;
            end
        end
    end

    // Monitor: logs handshakes with cycle stamps and tracks reads in flight plus buffered.
    int          cyc = 0;
    int          ar_cnt = 0, bt_cnt = 0, peak = 0, ar_hold_bad = 0;
    logic        prev_tv = 1'b0, prev_stall = 1'b0;
    logic [8:0]  prev_addr = '0;
    logic [15:0] beats[$];
    logic        lasts[$];
    logic [1:0]  users[$];
    int          bcyc[$];
    logic [8:0]  ars[$];
    int          rcycs[$];
    int          tvrise[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rstn) begin
            ar_cnt = 0;
            bt_cnt = 0;
            prev_tv = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(m_axil_arvalid && m_axil_araddr == prev_addr)) ar_hold_bad++;
            prev_stall = m_axil_arvalid && !m_axil_arready;
            prev_addr = m_axil_araddr;
            if (m_axis_tvalid && !prev_tv) tvrise.push_back(cyc);
            prev_tv = m_axis_tvalid;
            if (m_axil_rvalid && m_axil_rready) rcycs.push_back(cyc);
            if (m_axil_arvalid && m_axil_arready) begin
                ars.push_back(m_axil_araddr);
                ar_cnt++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                beats.push_back(m_axis_tdata);
                lasts.push_back(m_axis_tlast);
                bcyc.push_back(cyc);
`ifdef AXIL_STREAM_RRESP_TUSER_EN
                users.push_back(m_axis_tuser);
`else
                users.push_back(2'b00);
`endif
                bt_cnt++;
            end
            if (ar_cnt - bt_cnt > peak) peak = ar_cnt - bt_cnt;
        end
    end

    typedef struct {
        logic [8:0]  addr;
        logic [7:0]  len;
        int          stall;
        logic        throttle;
        int          exp_n;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
    } vec_t;

    // cmd_valid stays high for the whole command: a second acceptance would show as extra beats.
    task automatic run_vec(input vec_t v);
        int b0, a0, r0, t0, n, done_cyc, bad, lastcnt;
        logic done;
        logic [8:0] base, ea;
        logic [7:0] w;
        b0 = beats.size(); a0 = ars.size(); r0 = rcycs.size(); t0 = tvrise.size();
        done = 1'b0;
        done_cyc = 0;
        @(negedge clk);
        cmd_addr = v.addr; cmd_len = v.len; cmd_valid = 1'b1;
        m_axis_tready = (v.stall == 0); ar_throttle = v.throttle;
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        base = v.addr & 9'h1FE;
        check("ar_first", {22'd0, m_axil_arvalid, m_axil_araddr}, {22'd0, 1'b1, base});
        check("rd_err_clear", 32'(rd_err), 32'd0);
        check("busy_accept", {30'd0, busy, cmd_ready}, 32'b10);
        for (int c = 0; c < 4000; c++) begin
            if (c == v.stall) m_axis_tready = 1'b1;
            if (!busy) begin
                done = 1'b1;
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        ar_throttle = 1'b0;
        check("cmd_done", 32'(done), 32'd1);
        check("idle_ready", 32'(cmd_ready), 32'd1);
        n = beats.size() - b0;
        check("beat_count", n, v.exp_n);
        check("ar_count", ars.size() - a0, v.exp_n);
        if (n == v.exp_n && ars.size() - a0 == v.exp_n) begin
            check("first_beat", 32'(beats[b0]), 32'(v.exp_first));
            check("last_beat", 32'(beats[b0 + n - 1]), 32'(v.exp_last));
            bad = 0;
            lastcnt = 0;
            for (int i = 0; i < n; i++) begin
                w = base[8:1] + 8'(i);
                if (beats[b0 + i] !== 16'h1000 + {8'h00, w}) bad++;
                ea = base + 9'(2 * i);
                if (ars[a0 + i] !== ea) bad++;
                if (lasts[b0 + i]) lastcnt++;
            end
            check("data_addr_seq", bad, 0);
            check("tlast_final_only", {lastcnt, 31'd0} | 32'(lasts[b0 + n - 1]), {32'd1, 31'd0} | 32'd1);
            check("busy_falls_on_last", done_cyc, bcyc[b0 + n - 1]);
            if (rcycs.size() > r0 && tvrise.size() > t0)
                check("tvalid_latency", tvrise[t0] - rcycs[r0], 1);
            else
                check("tvalid_seen", 0, 1);
            if (v.stall == 0 && !v.throttle)
                check("throughput", bcyc[b0 + n - 1] - bcyc[b0], n - 1);
        end
    endtask

    vec_t vecs[6];

    initial begin
        int b0;
        logic ok;
        vecs[0] = '{9'h000, 8'd7,   0,  1'b0, 8,   16'h1000, 16'h1007};
        vecs[1] = '{9'h010, 8'd0,   0,  1'b0, 1,   16'h1008, 16'h1008};
        vecs[2] = '{9'h000, 8'd15,  20, 1'b0, 16,  16'h1000, 16'h100F};
        vecs[3] = '{9'h1FC, 8'd3,   0,  1'b0, 4,   16'h10FE, 16'h1001};
        vecs[4] = '{9'h011, 8'd1,   0,  1'b1, 2,   16'h1008, 16'h1009};
        vecs[5] = '{9'h1F0, 8'd255, 3,  1'b1, 256, 16'h10F8, 16'h10F7};

        repeat (3) @(negedge clk);
        check("reset_flags", {25'd0, cmd_ready, m_axil_arvalid, m_axil_rready, m_axis_tvalid,
              m_axis_tlast, busy, rd_err}, 32'b1000000);
        check("reset_araddr", 32'(m_axil_araddr), 32'd0);
        rstn = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Abort during beat 3; RAM slave shares the reset.
        b0 = beats.size();
        @(negedge clk);
        cmd_addr = 9'h000; cmd_len = 8'd7; cmd_valid = 1'b1; m_axis_tready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (beats.size() - b0 >= 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort_reached", 32'(ok), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        check("abort_flags", {25'd0, cmd_ready, m_axil_arvalid, m_axil_rready, m_axis_tvalid,
              m_axis_tlast, busy, rd_err}, 32'b1000000);
        check("abort_araddr", 32'(m_axil_araddr), 32'd0);
        rstn = 1'b1;
        run_vec('{9'h020, 8'd1, 0, 1'b0, 2, 16'h1010, 16'h1011});

        // Error response on beat 2.
        err_word = 2;
        b0 = beats.size();
        run_vec('{9'h000, 8'd7, 0, 1'b0, 8, 16'h1000, 16'h1007});
        check("rd_err_set", 32'(rd_err), 32'd1);
`ifdef AXIL_STREAM_RRESP_TUSER_EN
        if (beats.size() - b0 == 8) begin
            int nz;
            nz = 0;
            for (int i = 0; i < 8; i++) if (users[b0 + i] != 2'b00) nz++;
            check("tuser_count", nz, 1);
            check("tuser_beat2", 32'(users[b0 + 2]), 32'd2);
        end
`endif
        repeat (5) @(negedge clk);
        check("rd_err_sticky", 32'(rd_err), 32'd1);
        err_word = -1;
        run_vec('{9'h040, 8'd2, 0, 1'b0, 3, 16'h1020, 16'h1022});
        check("rd_err_stays_clear", 32'(rd_err), 32'd0);

        check("credit_peak", peak, 4);
        check("ar_hold_stable", ar_hold_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
